// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants, sync polarity and the registered output payload.
package vga_pkg;

  localparam int unsigned COORD_W = 10;

  localparam int unsigned VGA_H_VISIBLE = 640;
  localparam int unsigned VGA_H_FRONT   = 16;
  localparam int unsigned VGA_H_SYNC    = 96;
  localparam int unsigned VGA_H_BACK    = 48;
  localparam int unsigned VGA_H_TOTAL   = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;

  localparam int unsigned VGA_V_VISIBLE = 480;
  localparam int unsigned VGA_V_FRONT   = 10;
  localparam int unsigned VGA_V_SYNC    = 2;
  localparam int unsigned VGA_V_BACK    = 33;
  localparam int unsigned VGA_V_TOTAL   = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  localparam int unsigned VGA_PRESCALE  = 4;

  localparam logic SYNC_ACTIVE = 1'b0;

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    logic   pixel_strobe;
    logic   frame_start;
    logic   hsync;
    logic   vsync;
    logic   video_on;
    coord_t pixel_x;
    coord_t pixel_y;
  } vga_out_t;

  // Half-open window test: lo <= v < hi
  function automatic logic in_window(input coord_t v, input coord_t lo, input coord_t hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Timing bundle from the sync generator to the pixel/colour logic.
interface vga_sync_gen_if;
  import vga_pkg::*;

  logic   Pixel_Strobe;
  logic   Frame_Start;
  logic   HSync;
  logic   VSync;
  logic   Video_On;
  coord_t Pixel_X;
  coord_t Pixel_Y;

  modport master (
    output Pixel_Strobe, Frame_Start, HSync, VSync, Video_On, Pixel_X, Pixel_Y
  );

  modport slave (
    input  Pixel_Strobe, Frame_Start, HSync, VSync, Video_On, Pixel_X, Pixel_Y
  );

endinterface

// File: rtl/mod_counter.sv
// Modulo-N counter with enable; carry_c flags the enabled cycle that wraps to zero.
module mod_counter #(
  parameter int unsigned MODULUS = 800,
  parameter int unsigned WIDTH   = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             carry_c
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  assign carry_c = en && (count == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (en) begin
      count <= carry_c ? '0 : count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// 640x480@60 VGA timing in the master clock domain using a 1-in-PRESCALE pixel strobe.
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_VISIBLE = VGA_H_VISIBLE,
  parameter int unsigned H_FRONT   = VGA_H_FRONT,
  parameter int unsigned H_SYNC    = VGA_H_SYNC,
  parameter int unsigned H_BACK    = VGA_H_BACK,
  parameter int unsigned V_VISIBLE = VGA_V_VISIBLE,
  parameter int unsigned V_FRONT   = VGA_V_FRONT,
  parameter int unsigned V_SYNC    = VGA_V_SYNC,
  parameter int unsigned V_BACK    = VGA_V_BACK,
  parameter int unsigned PRESCALE  = VGA_PRESCALE
) (
  input  logic           Master_Clock_In,
  input  logic           Reset,
  vga_sync_gen_if.master vga
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned PRE_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam coord_t H_VIS_END  = COORD_W'(H_VISIBLE);
  localparam coord_t H_SYNC_LO  = COORD_W'(H_VISIBLE + H_FRONT);
  localparam coord_t H_SYNC_HI  = COORD_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam coord_t V_VIS_END  = COORD_W'(V_VISIBLE);
  localparam coord_t V_SYNC_LO  = COORD_W'(V_VISIBLE + V_FRONT);
  localparam coord_t V_SYNC_HI  = COORD_W'(V_VISIBLE + V_FRONT + V_SYNC);

  localparam vga_out_t OUT_RESET = '{
    pixel_strobe: 1'b0,
    frame_start:  1'b0,
    hsync:        ~SYNC_ACTIVE,
    vsync:        ~SYNC_ACTIVE,
    video_on:     1'b0,
    pixel_x:      '0,
    pixel_y:      '0
  };

  logic [PRE_W-1:0] prescale;
  logic             strobe_c;
  coord_t           h_count;
  coord_t           v_count;
  logic             h_carry;
  logic             v_wrap_unused;
  vga_out_t         out_nxt;
  vga_out_t         out_q;

  assign strobe_c = (prescale == PRE_LAST);

  always_ff @(posedge Master_Clock_In) begin
    if (Reset) begin
      prescale <= '0;
    end else begin
      prescale <= strobe_c ? '0 : prescale + PRE_W'(1);
    end
  end

  mod_counter #(.MODULUS(H_TOTAL), .WIDTH(COORD_W)) u_h_count (
    .clk     (Master_Clock_In),
    .rst     (Reset),
    .en      (strobe_c),
    .count   (h_count),
    .carry_c (h_carry)
  );

  mod_counter #(.MODULUS(V_TOTAL), .WIDTH(COORD_W)) u_v_count (
    .clk     (Master_Clock_In),
    .rst     (Reset),
    .en      (h_carry),
    .count   (v_count),
    .carry_c (v_wrap_unused)
  );

  // Decode from the live counters; everything is registered below so outputs stay aligned
  always_comb begin
    out_nxt              = OUT_RESET;
    out_nxt.pixel_strobe = strobe_c;
    out_nxt.frame_start  = strobe_c && (h_count == '0) && (v_count == '0);
    out_nxt.hsync        = in_window(h_count, H_SYNC_LO, H_SYNC_HI) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    out_nxt.vsync        = in_window(v_count, V_SYNC_LO, V_SYNC_HI) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    out_nxt.video_on     = (h_count < H_VIS_END) && (v_count < V_VIS_END);
    out_nxt.pixel_x      = h_count;
    out_nxt.pixel_y      = v_count;
  end

  always_ff @(posedge Master_Clock_In) begin
    if (Reset) begin
      out_q <= OUT_RESET;
    end else begin
      out_q <= out_nxt;
    end
  end

  assign vga.Pixel_Strobe = out_q.pixel_strobe;
  assign vga.Frame_Start  = out_q.frame_start;
  assign vga.HSync        = out_q.hsync;
  assign vga.VSync        = out_q.vsync;
  assign vga.Video_On     = out_q.video_on;
  assign vga.Pixel_X      = out_q.pixel_x;
  assign vga.Pixel_Y      = out_q.pixel_y;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen: real horizontal timing, shortened frame height.
module tb_vga_sync_gen;
  import vga_pkg::*;

  localparam int unsigned HV = 640, HF = 16, HS = 96, HB = 48, HT = 800;
  localparam int unsigned VV = 4, VF = 1, VS = 2, VB = 1, VT = 8;
  localparam int unsigned PS = 4;
  localparam int unsigned FRAME_CYC = HT * VT * PS;

  typedef struct {
    vga_out_t exp;
    bit       agg;
  } sb_item_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vga_sync_gen_if vga ();

  vga_sync_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .PRESCALE(PS)
  ) dut (
    .Master_Clock_In (clk),
    .Reset           (rst),
    .vga             (vga)
  );

  sb_item_t q[$];
  int checks = 0;
  int errors = 0;
  int nprint = 0;
  int unsigned t_run = 0;

  int hs_low = 0, vs_low = 0, von_cnt = 0, fs_cnt = 0, strobe_cnt = 0;
  int consec = 0, x_no_strobe = 0;
  logic   prev_strobe = 1'b0, prev_hs = 1'b1, prev_vs = 1'b1;
  coord_t prev_x = '0, prev_y = '0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Expected outputs after the edge that consumed counter state t (t edges since release)
  function automatic vga_out_t model(input int unsigned t);
    vga_out_t e;
    int unsigned s, h, v;
    s = t / PS;
    h = s % HT;
    v = (s / HT) % VT;
    e.pixel_strobe = ((t % PS) == PS - 1);
    e.frame_start  = e.pixel_strobe && (h == 0) && (v == 0);
    e.hsync        = (h >= HV + HF && h < HV + HF + HS) ? 1'b0 : 1'b1;
    e.vsync        = (v >= VV + VF && v < VV + VF + VS) ? 1'b0 : 1'b1;
    e.video_on     = (h < HV) && (v < VV);
    e.pixel_x      = COORD_W'(h);
    e.pixel_y      = COORD_W'(v);
    return e;
  endfunction

  function automatic vga_out_t reset_out();
    vga_out_t e;
    e.pixel_strobe = 1'b0;
    e.frame_start  = 1'b0;
    e.hsync        = 1'b1;
    e.vsync        = 1'b1;
    e.video_on     = 1'b0;
    e.pixel_x      = '0;
    e.pixel_y      = '0;
    return e;
  endfunction

  task automatic step(input logic r, input bit agg);
    sb_item_t it;
    rst = r;
    @(posedge clk);
    #1;
    if (r) begin
      t_run = 0;
      it.exp = reset_out();
    end else begin
      it.exp = model(t_run);
      t_run++;
    end
    it.agg = agg;
    q.push_back(it);
  endtask

  // Monitor: compare every presented cycle, and gather window statistics
  always @(negedge clk) begin
    sb_item_t it;
    vga_out_t act;
    act.pixel_strobe = vga.Pixel_Strobe;
    act.frame_start  = vga.Frame_Start;
    act.hsync        = vga.HSync;
    act.vsync        = vga.VSync;
    act.video_on     = vga.Video_On;
    act.pixel_x      = vga.Pixel_X;
    act.pixel_y      = vga.Pixel_Y;
    if (q.size() > 0) begin
      it = q.pop_front();
      checks++;
      if (act !== it.exp) begin
        errors++;
        if (nprint < 20)
          $display("FAIL cycle_compare at %0t actual=%h expected=%h", $time, act, it.exp);
        nprint++;
      end
      if (it.agg) begin
        if (!act.hsync) hs_low++;
        if (!act.vsync) vs_low++;
        if (act.video_on) von_cnt++;
        if (act.frame_start) fs_cnt++;
        if (act.pixel_strobe) strobe_cnt++;
        if (prev_strobe && act.pixel_strobe) consec++;
        if ((act.pixel_x != prev_x) && !prev_strobe) x_no_strobe++;
        if (prev_hs && !act.hsync) chk("hsync_fall_x", int'(act.pixel_x), HV + HF);
        if (!prev_hs && act.hsync) chk("hsync_rise_x", int'(act.pixel_x), HV + HF + HS);
        if (prev_vs && !act.vsync) chk("vsync_fall_y", int'(act.pixel_y), VV + VF);
        if (act.pixel_y != prev_y) chk("y_step_x", int'(act.pixel_x), 0);
      end
    end
    prev_strobe = act.pixel_strobe;
    prev_hs     = act.hsync;
    prev_vs     = act.vsync;
    prev_x      = act.pixel_x;
    prev_y      = act.pixel_y;
  end

  initial begin
    rst = 1'b1;
    // Reset hold, then run up to the strobe edge at pixel (300,2)
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    for (int i = 0; i < (2 * HT + 300) * PS + PS - 1; i++) step(1'b0, 1'b0);
    // Reset lands on the strobe edge: reset values, no increment, no Frame_Start
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    // One full frame from release, statistics window covers exactly FRAME_CYC cycles
    for (int i = 0; i < FRAME_CYC; i++) step(1'b0, 1'b1);
    // Through the frame wrap and the next Frame_Start
    for (int i = 0; i < 40; i++) step(1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", q.size(), 0);
    chk("hsync_low_cycles", hs_low, HS * PS * VT);
    chk("vsync_low_cycles", vs_low, VS * HT * PS);
    chk("video_on_cycles", von_cnt, HV * PS * VV);
    chk("frame_start_count", fs_cnt, 1);
    chk("strobe_count", strobe_cnt, HT * VT);
    chk("strobe_back_to_back", consec, 0);
    chk("x_change_no_strobe", x_no_strobe, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

- Consumes the 100 MHz master clock and produces 640×480@60 Hz VGA timing: HSync, VSync, a video-active flag and pixel coordinates.
- Runs entirely in the master clock domain, using an internal 1-in-4 pixel strobe (25 MHz effective) instead of a derived clock.
- Sits between the clock tree and the pixel/colour generation logic, which samples its outputs on Pixel_Strobe.

## Interface
Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16; H_SYNC, 96; H_BACK, 48: horizontal porch/sync widths in pixels (H_TOTAL = 800)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10; V_SYNC, 2; V_BACK, 33: vertical widths in lines (V_TOTAL = 525)
- PRESCALE, 4, master cycles per pixel

Ports:
- Master_Clock_In  in  1  100 MHz clock; the only clock
- Reset  in  1  synchronous, active-high reset
- Pixel_Strobe  out  1  one-cycle pulse on the last master cycle of each pixel slot
- Frame_Start  out  1  one-cycle pulse, coincident with Pixel_Strobe, at pixel (0,0)
- HSync  out  1  horizontal sync, active low
- VSync  out  1  vertical sync, active low
- Video_On  out  1  high while the current pixel is inside 640×480
- Pixel_X  out  10  horizontal count, 0..799
- Pixel_Y  out  10  vertical count, 0..524

## Operation
- **Prescaler:** 2-bit, counts 0..PRESCALE-1 and wraps. The strobe condition is prescaler == PRESCALE-1.
- **H counter:** increments on strobe; wraps 799→0 and emits a line carry.
- **V counter:** increments on line carry only; wraps 524→0.
- **Sync decode (from counters):**
  - HSync low for H in [656, 751]; VSync low for V in [490, 491].
  - Video_On = (H < 640) && (V < 480).
  - Frame_Start = strobe && H == 0 && V == 0.
- **Output registers:** every output, including Pixel_X/Y and Pixel_Strobe, is a registered copy of the decode. All outputs therefore lag the internal counter state by exactly one master cycle and stay mutually aligned.
- **Width rules:** counters are 10 bits unsigned. Comparisons against parameter sums are done at 10 bits, with no overflow possible since all sums are ≤ 800.
- **Reset:**
  - Reset high on an edge forces prescaler = 0, H = 0, V = 0.
  - Outputs reset to Pixel_Strobe = 0, Frame_Start = 0, HSync = 1, VSync = 1, Video_On = 0, Pixel_X = 0, Pixel_Y = 0.
  - Reset mid-frame abandons the frame immediately. There is no partial-line completion.

## Timing
- Cycle 0 is the first edge with Reset low.
- Outputs show pixel (0,0) from cycle 1. Video_On = 1 from cycle 1.
- The first Pixel_Strobe (and Frame_Start) is at cycle 4; Pixel_X = 1 from cycle 5.
- Each pixel is held for 4 master cycles. A line is 3200 cycles; a frame is 1,680,000 cycles.
- HSync falls on the master cycle where Pixel_X first reads 656 and rises where it first reads 752.
- Wrap boundaries:
  - At H = 799 with V = 524, the next strobe edge moves both counters to 0 together.
  - Frame_Start pulses on the strobe of the new (0,0) slot, not at the wrap edge.
- If Reset is asserted in the same cycle as a strobe/wrap, Reset wins: there is no increment and no Frame_Start pulse.

## Structure
- Shared package vga_pkg holds:
  - the timing constants (visible/porch/sync widths and the H_TOTAL, V_TOTAL derivations);
  - sync polarity (SYNC_ACTIVE = 1'b0);
  - the coordinate width constant (10).
- One sub-module, mod_counter, parameterised by modulus and width, with enable and a wrap-carry output. It is instantiated once for H (enable = strobe) and once for V (enable = H carry).
- The prescaler and output registers live in the top level.

## Test plan
1. **Reset release:** hold Reset 5 cycles then release → during reset HSync = VSync = 1, Video_On = 0; at cycle 1 Video_On = 1, Pixel_X = 0; Pixel_Strobe first high at cycle 4; Pixel_X = 1 at cycle 5.
2. **One full line:** run 3200 cycles after release → HSync low for exactly 384 master cycles (96 pixels), starting at Pixel_X = 656; Video_On high for 2560 cycles; Pixel_Y steps 0→1 when Pixel_X wraps 799→0.
3. **One full frame:**
   - VSync low for exactly 2 lines (6400 cycles), starting at Pixel_Y = 490.
   - Exactly one Frame_Start per 1,680,000 cycles.
   - Video_On never high for Pixel_Y ≥ 480.
4. **Frame wrap:** force run to (799,524) → the next strobe edge gives Pixel_X = 0, Pixel_Y = 0; Frame_Start pulses 4 cycles later with Pixel_Strobe.
5. **Mid-frame reset:** assert Reset at (300,200) on a strobe cycle → the next cycle shows all reset values with no Frame_Start; after release the timing sequence is identical to scenario 1.
6. **Strobe cadence:** over 10,000 cycles, Pixel_Strobe high exactly every 4th cycle, never two consecutive cycles, and Pixel_X changes only on the cycle after a strobe.
